// File: rtl/axi4_read_master_pkg.sv
// Shared AXI4 constants, read-completion codes and read-master state encoding.
// Imported by axi4_read_master and reusable by the companion write master.
package axi4_read_master_pkg;

   localparam int unsigned AXI_LEN_W   = 8;
   localparam int unsigned AXI_SIZE_W  = 3;
   localparam int unsigned AXI_BURST_W = 2;
   localparam int unsigned AXI_RESP_W  = 2;
   localparam int unsigned AXI_CACHE_W = 4;
   localparam int unsigned AXI_PROT_W  = 3;
   localparam int unsigned AXI_QOS_W   = 4;
   localparam int unsigned READ_ERR_W  = 2;

   localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

   // Normal non-cacheable bufferable
   localparam logic [AXI_CACHE_W-1:0] ARCACHE_DEFAULT = 4'b0011;

   // Completion codes, ordered by severity so a larger value always wins
   typedef enum logic [READ_ERR_W-1:0] {
      ERR_OK      = 2'd0,
      ERR_RESP    = 2'd1,
      ERR_PROTO   = 2'd2,
      ERR_TIMEOUT = 2'd3
   } read_error_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } read_state_e;

   // Error codes only ever escalate
   function automatic read_error_e err_max(input read_error_e a, input read_error_e b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/axi4_watchdog.sv
// Inactivity watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th enabled cycle without a clear.
// Ports: clk, rst (sync active-high), clear, enable, expired (combinational).
module axi4_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned      CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Saturating counter so a stalled owner keeps seeing expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/axi4_read_master.sv
// Single-burst AXI4 read master. One READ_START pulse issues one INCR burst;
// R beats are passed straight through to the user handshake with no storage,
// and a one-cycle READ_DONE reports the worst error seen.
// Ports: READ_* user request/beat/completion interface; M_AXI_AR* read address
// channel; M_AXI_R* read data channel; M_AXI_ACLK clock, M_AXI_ARESET sync reset.
module axi4_read_master
   import axi4_read_master_pkg::*;
#(
   parameter int unsigned C_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_AXI_DATA_WIDTH = 256,
   parameter int unsigned C_AXI_ID_WIDTH   = 4,
   parameter int unsigned C_TIMEOUT        = 1024
) (
   input  logic                        M_AXI_ACLK,
   input  logic                        M_AXI_ARESET,
   input  logic                        READ_START,
   input  logic [C_AXI_ADDR_WIDTH-1:0] READ_ADDR,
   input  logic [AXI_LEN_W-1:0]        READ_LEN,
   output logic                        READ_BUSY,
   output logic [C_AXI_DATA_WIDTH-1:0] READ_DATA,
   output logic                        READ_VALID,
   input  logic                        READ_READY,
   output logic                        READ_DONE,
   output logic [READ_ERR_W-1:0]       READ_ERROR,
   output logic [C_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [AXI_LEN_W-1:0]        M_AXI_ARLEN,
   output logic [AXI_SIZE_W-1:0]       M_AXI_ARSIZE,
   output logic [AXI_BURST_W-1:0]      M_AXI_ARBURST,
   output logic                        M_AXI_ARLOCK,
   output logic [AXI_CACHE_W-1:0]      M_AXI_ARCACHE,
   output logic [AXI_PROT_W-1:0]       M_AXI_ARPROT,
   output logic [AXI_QOS_W-1:0]        M_AXI_ARQOS,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   input  logic [C_AXI_ID_WIDTH-1:0]   M_AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [AXI_RESP_W-1:0]       M_AXI_RRESP,
   input  logic                        M_AXI_RLAST,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY
);

   localparam int unsigned SIZE_LOG2 = $clog2(C_AXI_DATA_WIDTH / 8);

   read_state_e                 state;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_LEN_W-1:0]        len_q;
   logic [AXI_LEN_W-1:0]        beat_q;
   read_error_e                 err_q;
   logic                        arvalid_q;
   logic                        busy_q;
   logic                        done_q;

   logic        start_ok;
   logic        ar_hs;
   logic        r_hs;
   logic        wd_expired;
   logic        beat_final;
   logic        resp_err;
   logic        proto_err;
   logic        beat_ends;
   read_error_e beat_err;

   assign start_ok = (state == IDLE) && READ_START;
   assign ar_hs    = arvalid_q && M_AXI_ARREADY;
   assign r_hs     = (state == DATA) && M_AXI_RVALID && READ_READY;

   // Per-beat classification: a beat ends the burst on RLAST or when the count
   // says it must be last; any disagreement between the two is a protocol error
   assign beat_final = (beat_q == len_q);
   assign resp_err   = (M_AXI_RRESP == RESP_SLVERR) || (M_AXI_RRESP == RESP_DECERR);
   assign proto_err  = (M_AXI_RLAST != beat_final) || (M_AXI_RID != '0);
   assign beat_ends  = M_AXI_RLAST || beat_final;
   assign beat_err   = err_max(err_q, err_max(resp_err  ? ERR_RESP  : ERR_OK,
                                              proto_err ? ERR_PROTO : ERR_OK));

   // Timer restarts on request acceptance and on every channel handshake
   axi4_watchdog #(
      .TIMEOUT (C_TIMEOUT)
   ) u_watchdog (
      .clk     (M_AXI_ACLK),
      .rst     (M_AXI_ARESET),
      .clear   (start_ok || ar_hs || r_hs),
      .enable  ((state == ADDR) || (state == DATA)),
      .expired (wd_expired)
   );

   // Control FSM; handshakes take priority over a coincident timeout
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state     <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         err_q     <= ERR_OK;
         arvalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (READ_START) begin
                  addr_q    <= READ_ADDR;
                  len_q     <= READ_LEN;
                  beat_q    <= '0;
                  err_q     <= ERR_OK;
                  arvalid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  state     <= DATA;
               end else if (wd_expired) begin
                  // Withdrawing ARVALID unaccepted is deliberate error recovery
                  arvalid_q <= 1'b0;
                  err_q     <= ERR_TIMEOUT;
                  done_q    <= 1'b1;
                  state     <= DONE;
               end
            end
            DATA: begin
               if (r_hs) begin
                  beat_q <= beat_q + AXI_LEN_W'(1);
                  err_q  <= beat_err;
                  if (beat_ends) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end else if (wd_expired) begin
                  err_q  <= ERR_TIMEOUT;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign READ_BUSY  = busy_q;
   assign READ_DONE  = done_q;
   assign READ_ERROR = err_q;

   // Zero-latency beat pass-through while in the data phase
   assign READ_DATA    = M_AXI_RDATA;
   assign READ_VALID   = (state == DATA) && M_AXI_RVALID;
   assign M_AXI_RREADY = (state == DATA) && READ_READY;

   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = len_q;
   assign M_AXI_ARSIZE  = AXI_SIZE_W'(SIZE_LOG2);
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = ARCACHE_DEFAULT;
   assign M_AXI_ARPROT  = '0;
   assign M_AXI_ARQOS   = '0;
   assign M_AXI_ARVALID = arvalid_q;

endmodule

// File: tb/tb_axi4_read_master.sv
// Directed bench for axi4_read_master: a slave/user driver, a transaction-level
// reference model, and a per-cycle compare process.
module tb_axi4_read_master;
   import axi4_read_master_pkg::*;

   localparam int unsigned TO = 16;

   logic         clk;
   logic         rst;
   logic         read_start;
   logic [31:0]  read_addr;
   logic [7:0]   read_len;
   logic         read_busy;
   logic [255:0] read_data;
   logic         read_valid;
   logic         read_ready;
   logic         read_done;
   logic [1:0]   read_error;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arlock;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic [3:0]   arqos;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [255:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   axi4_read_master #(
      .C_AXI_ADDR_WIDTH (32),
      .C_AXI_DATA_WIDTH (256),
      .C_AXI_ID_WIDTH   (4),
      .C_TIMEOUT        (TO)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESET  (rst),
      .READ_START    (read_start),
      .READ_ADDR     (read_addr),
      .READ_LEN      (read_len),
      .READ_BUSY     (read_busy),
      .READ_DATA     (read_data),
      .READ_VALID    (read_valid),
      .READ_READY    (read_ready),
      .READ_DONE     (read_done),
      .READ_ERROR    (read_error),
      .M_AXI_ARID    (arid),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARLEN   (arlen),
      .M_AXI_ARSIZE  (arsize),
      .M_AXI_ARBURST (arburst),
      .M_AXI_ARLOCK  (arlock),
      .M_AXI_ARCACHE (arcache),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_ARQOS   (arqos),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RID     (rid),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RLAST   (rlast),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Slave beat script
   logic [255:0] b_data [32];
   logic [1:0]   b_resp [32];
   bit           b_last [32];
   logic [3:0]   b_rid  [32];
   int           n_offer;

   // Expectations for the current transaction
   logic [255:0] exp_q [$];
   int           exp_end;
   logic [1:0]   exp_err;
   logic [31:0]  exp_addr;
   logic [7:0]   exp_len;

   // Model of the externally visible transaction phase
   bit chk_en = 1'b0;
   bit m_busy, m_ar, m_data, m_done, m_to;
   int m_timer, m_beat;

   // Observations for literal checks
   logic [1:0]   seen_err;
   int           seen_beats;
   logic [255:0] last_data;
   int           done_cyc;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] emax(input logic [1:0] a, input logic [1:0] b);
      return (b > a) ? b : a;
   endfunction

   // Which beat closes the burst and what the completion code must be
   function automatic void model_txn(input logic [7:0] len, output int end_idx, output logic [1:0] err);
      err     = 2'd0;
      end_idx = int'(len);
      for (int i = 0; i <= int'(len); i++) begin
         if (b_resp[i] == RESP_SLVERR || b_resp[i] == RESP_DECERR) err = emax(err, 2'd1);
         if (b_rid[i] != 4'd0 || b_last[i] != (i == int'(len)))    err = emax(err, 2'd2);
         if (b_last[i] || i == int'(len)) begin
            end_idx = i;
            break;
         end
      end
   endfunction

   task automatic fill_beats(input int len, input logic [31:0] base);
      for (int i = 0; i < 32; i++) begin
         b_data[i] = {8{base + 32'(i)}};
         b_resp[i] = RESP_OKAY;
         b_last[i] = (i == len);
         b_rid[i]  = 4'd0;
      end
      n_offer = len + 1;
   endtask

   // Compare process
   always @(negedge clk) begin
      logic [255:0] e;
      if (chk_en) begin
         check("busy",       256'(read_busy),  256'(m_busy));
         check("arvalid",    256'(arvalid),    256'(m_ar));
         check("read_done",  256'(read_done),  256'(m_done));
         check("rready",     256'(rready),     256'(m_data && read_ready));
         check("read_valid", 256'(read_valid), 256'(m_data && rvalid));
         if (arvalid) begin
            check("araddr", 256'(araddr), 256'(exp_addr));
            check("arlen",  256'(arlen),  256'(exp_len));
            check("ar_const", 256'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                  256'({4'd0, 3'd5, 2'd1, 1'b0, 4'b0011, 3'd0, 4'd0}));
         end
         if (read_done) begin
            seen_err   = read_error;
            seen_beats = m_beat;
            check("read_error", 256'(read_error), 256'(m_to ? 2'd3 : exp_err));
            check("beats_left", 256'(exp_q.size()), 256'(0));
         end
         if (read_valid && read_ready && !rst) begin
            last_data = read_data;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 'x;
            check("beat_data", read_data, e);
         end
         if (rst) begin
            {m_busy, m_ar, m_data, m_done, m_to} = '0;
            m_timer = 0;
            m_beat  = 0;
            exp_q.delete();
         end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
         end else if (m_ar) begin
            if (arready) begin
               m_ar = 1'b0; m_data = 1'b1; m_timer = 0;
            end else if (++m_timer == int'(TO)) begin
               m_ar = 1'b0; m_done = 1'b1; m_to = 1'b1;
            end
         end else if (m_data) begin
            if (rvalid && read_ready) begin
               m_timer = 0;
               if (m_beat == exp_end) begin
                  m_data = 1'b0; m_done = 1'b1;
               end
               m_beat++;
            end else if (++m_timer == int'(TO)) begin
               m_data = 1'b0; m_done = 1'b1; m_to = 1'b1;
            end
         end else if (read_start && !m_busy) begin
            m_busy = 1'b1; m_ar = 1'b1; m_timer = 0; m_beat = 0; m_to = 1'b0;
         end
      end
   end

   // Drives one request plus the slave and user sides until READ_DONE
   task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input int ar_wait,
                          input bit ar_never, input bit rv_rand, input bit rr_toggle,
                          input int rst_at, input bit start_in_done);
      int e_end;
      logic [1:0] e_err;
      int ar_cnt = 0;
      int sent   = 0;
      int cyc    = 0;
      bit ar_ok  = 1'b0;
      bit rv     = 1'b0;
      bit fin    = 1'b0;
      bit hit    = 1'b0;
      model_txn(len, e_end, e_err);
      exp_end  = e_end;
      exp_err  = ar_never ? 2'd3 : e_err;
      exp_addr = addr;
      exp_len  = len;
      exp_q.delete();
      if (!ar_never) for (int i = 0; i <= e_end; i++) exp_q.push_back(b_data[i]);
      read_start = 1'b1;
      read_addr  = addr;
      read_len   = len;
      @(posedge clk); #1;
      read_start = 1'b0;
      read_addr  = ~addr;
      read_len   = ~len;
      read_ready = 1'b1;
      done_cyc   = -1;
      while (!fin && cyc < 300) begin
         arready = !ar_ok && !ar_never && (ar_cnt >= ar_wait);
         if (ar_ok && !rv && sent < n_offer) rv = rv_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         rvalid = rv;
         if (rv) begin
            rdata = b_data[sent];
            rresp = b_resp[sent];
            rlast = b_last[sent];
            rid   = b_rid[sent];
         end
         if (rr_toggle) read_ready = ~read_ready;
         if (rst_at >= 0 && ar_ok && rv && sent == rst_at) rst = 1'b1;
         @(negedge clk);
         if (arvalid) ar_cnt++;
         if (arvalid && arready) ar_ok = 1'b1;
         if (rvalid && rready) begin
            hit = (sent == e_end);
            sent++;
            rv = 1'b0;
         end
         if (read_done) begin
            fin      = 1'b1;
            done_cyc = cyc;
         end
         @(posedge clk); #1;
         if (rst) begin
            rst = 1'b0;
            fin = 1'b1;
         end
         if (start_in_done && hit) begin
            read_start = 1'b1;
            hit        = 1'b0;
         end else begin
            read_start = 1'b0;
         end
         cyc++;
      end
      check("budget", 256'(fin), 256'(1));
      arready    = 1'b0;
      rvalid     = 1'b0;
      rlast      = 1'b0;
      read_ready = 1'b0;
      read_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1; read_start = 1'b0; read_addr = '0; read_len = '0; read_ready = 1'b0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",   256'(read_busy),  256'(0));
      check("rst_arvalid",256'(arvalid),    256'(0));
      check("rst_done",   256'(read_done),  256'(0));
      check("rst_error",  256'(read_error), 256'(0));
      check("rst_araddr", 256'(araddr),     256'(0));
      check("rst_arlen",  256'(arlen),      256'(0));
      @(posedge clk); #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      idle(2);

      // Single beat, ARREADY after 3 cycles
      fill_beats(0, 32'h0);
      b_data[0] = 256'hD0000000;
      run_txn(32'hA0001000, 8'd0, 3, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("t1_err",   256'(seen_err),   256'(0));
      check("t1_beats", 256'(seen_beats), 256'(1));
      check("t1_data",  last_data,        256'hD0000000);
      check("t1_lat",   256'(done_cyc),   256'(5));
      idle(2);

      // 16 beats with random RVALID and toggling READ_READY
      fill_beats(15, 32'h1000_0000);
      run_txn(32'h0000_2000, 8'd15, 0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
      check("t2_err",   256'(seen_err),   256'(0));
      check("t2_beats", 256'(seen_beats), 256'(16));
      check("t2_data",  last_data,        {8{32'h1000_000F}});
      idle(2);

      // SLVERR on beat 2; also a READ_START during DONE that must be ignored
      fill_beats(3, 32'h2000_0000);
      b_resp[2] = RESP_SLVERR;
      run_txn(32'h0000_3000, 8'd3, 1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
      check("t3_err",   256'(seen_err),   256'(1));
      check("t3_beats", 256'(seen_beats), 256'(4));
      idle(3);

      // Early RLAST on beat 1
      fill_beats(3, 32'h3000_0000);
      b_last[3] = 1'b0;
      b_last[1] = 1'b1;
      n_offer   = 4;
      run_txn(32'h0000_4000, 8'd3, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("t4a_err",   256'(seen_err),   256'(2));
      check("t4a_beats", 256'(seen_beats), 256'(2));
      idle(2);

      // RLAST never asserted
      fill_beats(3, 32'h4000_0000);
      b_last[3] = 1'b0;
      run_txn(32'h0000_5000, 8'd3, 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("t4b_err",   256'(seen_err),   256'(2));
      check("t4b_beats", 256'(seen_beats), 256'(4));
      idle(2);

      // Wrong RID plus DECERR: the higher code must win
      fill_beats(1, 32'h5000_0000);
      b_rid[0]  = 4'h3;
      b_resp[1] = RESP_DECERR;
      run_txn(32'hFFFF_F000, 8'd1, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("t5_err",   256'(seen_err),   256'(2));
      check("t5_beats", 256'(seen_beats), 256'(2));
      idle(2);

      // ARREADY never comes: timeout
      fill_beats(0, 32'h6000_0000);
      run_txn(32'h0000_6000, 8'd0, 0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      check("t6_err",    256'(seen_err),               256'(3));
      check("t6_within", 256'(done_cyc >= 0 && done_cyc <= 18), 256'(1));
      check("t6_beats",  256'(seen_beats),             256'(0));
      idle(2);

      // Reset during beat 5 of 8, then a clean transaction
      fill_beats(7, 32'h7000_0000);
      run_txn(32'h0000_7000, 8'd7, 0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
      @(negedge clk);
      check("t7_busy",   256'(read_busy),  256'(0));
      check("t7_arvalid",256'(arvalid),    256'(0));
      check("t7_rready", 256'(rready),     256'(0));
      check("t7_error",  256'(read_error), 256'(0));
      check("t7_araddr", 256'(araddr),     256'(0));
      check("t7_arlen",  256'(arlen),      256'(0));
      idle(2);
      fill_beats(1, 32'h8000_0000);
      run_txn(32'h0000_8000, 8'd1, 1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      check("t8_err",   256'(seen_err),   256'(0));
      check("t8_beats", 256'(seen_beats), 256'(2));
      check("t8_data",  last_data,        {8{32'h8000_0001}});
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
